reg_scoreboard: RTL and testbench

- Tracks in-flight writes to GPRs $1..$31 for the pipelined MIPS core, on the reader side of the register-file write port.
- Decode presents each instruction's source and destination registers. The block answers whether the instruction may issue now, and whether each source must come from bypass rather than the register file.
- Writeback completions retire pending writes.
- Sits between decode/issue control and the register file write-back path.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/sb_entry.sv | 42 ++++
 rtl/reg_scoreboard.sv | 68 ++++++
 tb/tb_reg_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core control blocks.
package cpu_pkg;
  localparam int NREG = 32;
  localparam int CNTW = 2;
  localparam int LATW = 3;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: in-flight writer count and forwarding countdown for a GPR.
module sb_entry
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set,
  input  logic            clr,
  input  logic [LATW-1:0] lat,
  output logic            pending,
  output logic            ready,
  output logic            full,
  output logic            underflow
);

  logic [CNTW-1:0] cnt;
  logic [LATW-1:0] tmr;
  logic [LATW-1:0] tmr_dec;

  assign tmr_dec   = (tmr != '0) ? tmr - 1'b1 : tmr;
  assign pending   = (cnt != '0);
  assign ready     = (tmr == '0);
  assign full      = (cnt == CNT_MAX);
  // A writeback racing a same-register issue is covered by that issue.
  assign underflow = clr && !set && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      tmr <= '0;
    end else if (set) begin
      tmr <= lat;
      if (!clr) cnt <= cnt + 1'b1;
    end else if (clr && cnt != '0) begin
      cnt <= cnt - 1'b1;
      tmr <= (cnt == CNTW'(1)) ? '0 : tmr_dec;
    end else begin
      tmr <= tmr_dec;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// GPR scoreboard: issue stall, bypass select and writeback retirement.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rs,
  input  logic [4:0]      iss_rt,
  input  logic            iss_use_rs,
  input  logic            iss_use_rt,
  input  logic            iss_we,
  input  logic [4:0]      iss_dst,
  input  logic [LATW-1:0] iss_lat,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dst,
  output logic            fwd_rs,
  output logic            fwd_rt,
  output logic            err
);

  logic [NREG-1:0] pend_v;
  logic [NREG-1:0] rdy_v;
  logic [NREG-1:0] full_v;
  logic [NREG-1:0] unf_v;
  logic            busy_rs;
  logic            busy_rt;
  logic            full;
  logic            accept;
  logic            wb_hit;

  // $0 has no slot; its constant bits make it look permanently idle.
  assign pend_v[0] = 1'b0;
  assign rdy_v[0]  = 1'b1;
  assign full_v[0] = 1'b0;
  assign unf_v[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry u_ent (
      .clk       (clk),
      .reset     (reset),
      .set       (accept && (iss_dst == 5'(r))),
      .clr       (wb_hit && (wb_dst == 5'(r))),
      .lat       (iss_lat),
      .pending   (pend_v[r]),
      .ready     (rdy_v[r]),
      .full      (full_v[r]),
      .underflow (unf_v[r])
    );
  end

  assign busy_rs = iss_use_rs && (iss_rs != REG_ZERO) && pend_v[iss_rs] && !rdy_v[iss_rs];
  assign busy_rt = iss_use_rt && (iss_rt != REG_ZERO) && pend_v[iss_rt] && !rdy_v[iss_rt];
  assign fwd_rs  = iss_use_rs && (iss_rs != REG_ZERO) && pend_v[iss_rs] && rdy_v[iss_rs];
  assign fwd_rt  = iss_use_rt && (iss_rt != REG_ZERO) && pend_v[iss_rt] && rdy_v[iss_rt];
  assign full    = iss_we && (iss_dst != REG_ZERO) && full_v[iss_dst];

  assign iss_ready = !(busy_rs || busy_rt || full);
  assign accept    = iss_valid && iss_ready && iss_we && (iss_dst != REG_ZERO);
  assign wb_hit    = wb_valid && (wb_dst != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset)       err <= 1'b0;
    else if (|unf_v) err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            iss_valid;
  logic            iss_ready;
  logic [4:0]      iss_rs;
  logic [4:0]      iss_rt;
  logic            iss_use_rs;
  logic            iss_use_rt;
  logic            iss_we;
  logic [4:0]      iss_dst;
  logic [LATW-1:0] iss_lat;
  logic            wb_valid;
  logic [4:0]      wb_dst;
  logic            fwd_rs;
  logic            fwd_rt;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_rs     (iss_rs),
    .iss_rt     (iss_rt),
    .iss_use_rs (iss_use_rs),
    .iss_use_rt (iss_use_rt),
    .iss_we     (iss_we),
    .iss_dst    (iss_dst),
    .iss_lat    (iss_lat),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .err        (err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rs = 0; iss_use_rt = 0;
    iss_we = 0; iss_dst = 0; iss_lat = 0; wb_valid = 0; wb_dst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [LATW-1:0] lat);
    iss_valid = 1; iss_we = 1; iss_dst = dst; iss_lat = lat;
  endtask

  task automatic wb(input logic [4:0] dst);
    wb_valid = 1; wb_dst = dst;
  endtask

  task automatic query_rs(input logic [4:0] r);
    iss_use_rs = 1; iss_rs = r;
  endtask

  initial begin
    clr_in();
    reset = 1;
    step(); step();
    reset = 0;

    // Clean state after reset
    query_rs(5); #1;
    chk("rst_ready", iss_ready, 1'b1);
    chk("rst_fwd_rs", fwd_rs, 1'b0);
    chk("rst_err", err, 1'b0);

    // dst=8 lat=2: stall two cycles, then forward, then retire
    clr_in(); issue(8, 2); #1;
    chk("iss8_ready", iss_ready, 1'b1);
    step();
    clr_in(); query_rs(8); #1;
    chk("r8_t2_stall", iss_ready, 1'b0);
    chk("r8_t2_fwd", fwd_rs, 1'b0);
    step();
    clr_in(); iss_use_rt = 1; iss_rt = 8; #1;
    chk("r8_t1_rt_stall", iss_ready, 1'b0);
    step();
    clr_in(); query_rs(8); iss_use_rt = 1; iss_rt = 8; #1;
    chk("r8_t0_ready", iss_ready, 1'b1);
    chk("r8_t0_fwd_rs", fwd_rs, 1'b1);
    chk("r8_t0_fwd_rt", fwd_rt, 1'b1);
    iss_use_rs = 0; #1;
    chk("r8_unused_rs", fwd_rs, 1'b0);
    clr_in(); wb(8);
    step();
    clr_in(); query_rs(8); #1;
    chk("r8_wb_fwd", fwd_rs, 1'b0);
    chk("r8_wb_ready", iss_ready, 1'b1);

    // Three writers to $3 saturate the counter
    clr_in(); issue(3, 1); step();
    step();
    step();
    clr_in(); issue(3, 1); #1;
    chk("r3_full_stall", iss_ready, 1'b0);
    clr_in(); wb(3);
    step();
    clr_in(); issue(3, 1); iss_valid = 0; #1;
    chk("r3_after_wb", iss_ready, 1'b1);
    clr_in(); wb(3); step();
    step();
    clr_in(); query_rs(3); #1;
    chk("r3_drained_fwd", fwd_rs, 1'b0);
    chk("r3_drained_err", err, 1'b0);

    // Same-cycle issue and writeback on $9: issue wins, count stays 1
    clr_in(); issue(9, 1); step();
    clr_in(); issue(9, 4); wb(9); #1;
    chk("r9_race_ready", iss_ready, 1'b1);
    step();
    clr_in(); query_rs(9);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("r9_stall_%0d", i), iss_ready, 1'b0);
      step();
    end
    chk("r9_fwd", fwd_rs, 1'b1);
    chk("r9_ready", iss_ready, 1'b1);
    chk("r9_err", err, 1'b0);
    clr_in(); wb(9); step();
    clr_in(); query_rs(9); #1;
    chk("r9_retired", fwd_rs, 1'b0);

    // Issue and writeback to idle $10 together: no error, stays idle
    clr_in(); issue(10, 0); wb(10); step();
    clr_in(); query_rs(10); #1;
    chk("r10_race_err", err, 1'b0);
    chk("r10_race_fwd", fwd_rs, 1'b0);

    // lat=0: pending but immediately forwardable
    clr_in(); issue(11, 0); step();
    clr_in(); query_rs(11); #1;
    chk("r11_lat0_ready", iss_ready, 1'b1);
    chk("r11_lat0_fwd", fwd_rs, 1'b1);
    clr_in(); wb(11); step();

    // Source equal to own destination sees pre-issue state
    clr_in(); issue(13, 3); query_rs(13); #1;
    chk("r13_self_ready", iss_ready, 1'b1);
    chk("r13_self_fwd", fwd_rs, 1'b0);
    step();
    clr_in(); query_rs(13); #1;
    chk("r13_after_stall", iss_ready, 1'b0);
    clr_in(); wb(13); step();

    // Writeback error handling
    clr_in(); wb(0); step();
    clr_in(); #1;
    chk("wb0_no_err", err, 1'b0);
    wb(12); step();
    clr_in(); #1;
    chk("wb12_err", err, 1'b1);
    step();
    chk("err_sticky", err, 1'b1);
    reset = 1; step();
    reset = 0; #1;
    chk("err_reset", err, 1'b0);

    // $0 is never tracked
    clr_in(); issue(0, 5); step();
    clr_in(); query_rs(0); #1;
    chk("r0_ready", iss_ready, 1'b1);
    chk("r0_fwd", fwd_rs, 1'b0);

    // Reset clears pending $7 and overrides a same-cycle issue
    clr_in(); issue(7, 3); step();
    clr_in(); query_rs(7); #1;
    chk("r7_pending", iss_ready, 1'b0);
    clr_in(); issue(7, 5); reset = 1; step();
    reset = 0; clr_in(); query_rs(7); #1;
    chk("r7_reset_ready", iss_ready, 1'b1);
    chk("r7_reset_fwd", fwd_rs, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
